memory_bus_arbiter: RTL and testbench
=====================================

# memory_bus_arbiter

Two-requester arbiter that shares the single 32-bit-word memory bus (address / dataWrite / dataRead / writeEnable / strobe / ready) between a CPU core and a second bus master, such as a program loader or debug port. It sits between the requesters' bus-master side and the memory block's bus side. It serialises complete strobe/ready transactions using round-robin priority and latches the request at grant. A watchdog aborts transactions the memory never acknowledges.

## Interface
- ADDRESS_SIZE, 15, address lines for 32-bit words; identical on all ports.
- TIMEOUT_CYCLES, 0, maximum cycles to wait for memReady; 0 disables the watchdog.
- clock  in  1  all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- m0Address / m1Address  in  ADDRESS_SIZE  requester word address; m0 is the CPU.
- m0DataWrite / m1DataWrite  in  32  store data.
- m0WriteEnable / m1WriteEnable  in  1  1 = write, 0 = read.
- m0Strobe / m1Strobe  in  1  request; held high until the matching ready is seen.
- m0DataRead / m1DataRead  out  32  read data; valid while the matching ready is high.
- m0Ready / m1Ready  out  1  transaction complete.
- memAddress  out  ADDRESS_SIZE; memDataWrite  out  32; memWriteEnable  out  1; memStrobe  out  1.
- memDataRead  in  32; memReady  in  1.
- grant  out  2  one-hot owner of the bus; 2'b00 when idle.
- busError  out  1  sticky watchdog flag; cleared only by reset.

## Operation
- All outputs are registered. Reset values are 0 for every output, including grant. lastGrant resets to 1, so m0 wins the first tie.
- States:
  - IDLE: memStrobe = 0, grant = 0.
    - If exactly one mXStrobe is high, grant that requester.
    - If both are high, grant the requester that is not lastGrant.
    - On grant: latch mXAddress, mXDataWrite and mXWriteEnable onto the mem outputs, set memStrobe = 1, update lastGrant, clear the watchdog counter, go to BUSY.
  - BUSY: requester inputs are ignored, because the latched copy is in use.
    - On memReady = 1: set memStrobe = 0, copy memDataRead into the granted mXDataRead, set mXReady = 1, go to DONE.
    - Otherwise, if TIMEOUT_CYCLES != 0, increment the counter. When the counter reaches TIMEOUT_CYCLES: set memStrobe = 0, mXDataRead = 32'hFFFF_FFFF, mXReady = 1, busError = 1, go to DONE.
  - DONE: hold mXReady and mXDataRead. When the granted mXStrobe is sampled low: set mXReady = 0, grant = 0, memWriteEnable = 0, go to IDLE.
- Writes: data is still copied into mXDataRead (a don't-care value for the requester); ready semantics are identical to reads.
- Dropping strobe during BUSY does not abort the transaction. The memory transaction completes, and ready then pulses for exactly one cycle because strobe is already low in DONE.
- The non-granted requester sees ready = 0 and its dataRead unchanged. Its strobe stays pending and is served at the next IDLE.
- busError stays high after a timeout; later transactions proceed normally.
- Counter width is $clog2(TIMEOUT_CYCLES+1), with a minimum of 1. The counter saturates and never wraps.
- Asserting reset mid-transaction drops memStrobe, every ready and grant immediately; the state returns to IDLE.

## Timing
- Request to memStrobe: 1 cycle. A strobe sampled at edge E gives memStrobe and grant high after E.
- memReady to requester: memReady sampled at edge K gives mXReady high and memStrobe low after K.
- Ready release: strobe sampled low at edge J gives mXReady low after J, state IDLE.
  - The earliest next grant is at edge J+1.
  - One idle cycle always separates transactions; the bus is never re-granted in the same cycle it is released.
- Zero-wait memory (memReady combinational on memStrobe), CPU-style requester: 4 cycles per transaction. The sequence is grant, complete, requester drops strobe, release.
- Timeout: memStrobe stays high for exactly TIMEOUT_CYCLES cycles before the abort edge.
- Both requesters pending continuously: grants alternate m0, m1, m0, …

## Test plan
- Single read: m0 reads address 0x12 and the memory returns 0xDEADBEEF with 2 wait states. Expect memAddress = 0x12, memWriteEnable = 0, memStrobe for 3 cycles, m0DataRead = 0xDEADBEEF with m0Ready, grant = 01 throughout, and m1Ready never asserted.
- Simultaneous requests after reset: m0 and m1 raise strobe on the same edge, and both re-request after each completion. Expect grant sequence 01, 10, 01, 10, each memAddress matching the granted requester, and no overlapping memStrobe.
- Write latching: m1 writes 0xCAFEF00D to address 0x7FFF and changes m1Address/m1DataWrite during BUSY. Expect memDataWrite = 0xCAFEF00D and memAddress = 0x7FFF to stay stable until memReady.
- Timeout: TIMEOUT_CYCLES = 8 and memReady is never asserted for an m0 read. Expect memStrobe high for exactly 8 cycles, then m0Ready with data 0xFFFFFFFF and busError = 1. A following normal read completes while busError stays 1.
- Reset mid-transaction: reset goes low during BUSY. Expect memStrobe, ready outputs and grant at 0 without waiting for a clock edge. After release, m0 wins the next tie.
- Early strobe drop: m1 drops strobe during BUSY. Expect m1Ready high for exactly 1 cycle after memReady, then IDLE.

Source files
------------

// File: rtl/memory_bus_arbiter.sv
// Two-requester round-robin arbiter for a single strobe/ready word memory bus.
// Each transaction is latched at grant, served to completion (or aborted by the
// optional watchdog) and released once the granted requester drops its strobe.
module memory_bus_arbiter #(
    parameter int unsigned ADDRESS_SIZE   = 15,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic [ADDRESS_SIZE-1:0] i_m0_address,
    input  logic [31:0]             i_m0_data_write,
    input  logic                    i_m0_write_enable,
    input  logic                    i_m0_strobe,
    output logic [31:0]             o_m0_data_read,
    output logic                    o_m0_ready,
    input  logic [ADDRESS_SIZE-1:0] i_m1_address,
    input  logic [31:0]             i_m1_data_write,
    input  logic                    i_m1_write_enable,
    input  logic                    i_m1_strobe,
    output logic [31:0]             o_m1_data_read,
    output logic                    o_m1_ready,
    output logic [ADDRESS_SIZE-1:0] o_mem_address,
    output logic [31:0]             o_mem_data_write,
    output logic                    o_mem_write_enable,
    output logic                    o_mem_strobe,
    input  logic [31:0]             i_mem_data_read,
    input  logic                    i_mem_ready,
    output logic [1:0]              o_grant,
    output logic                    o_bus_error
);

    localparam int unsigned CountWidth =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Abort fires on the edge where the counter would reach TIMEOUT_CYCLES, so
    // memStrobe is high for exactly TIMEOUT_CYCLES cycles.
    localparam logic [CountWidth-1:0] LastCount =
        (TIMEOUT_CYCLES == 0) ? '0 : CountWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  r_state, w_state_d;
    logic                    r_last_grant, w_last_grant_d;  // 1 = m1 was served last
    logic [1:0]              r_grant, w_grant_d;
    logic [ADDRESS_SIZE-1:0] r_mem_address, w_mem_address_d;
    logic [31:0]             r_mem_data_write, w_mem_data_write_d;
    logic                    r_mem_write_enable, w_mem_write_enable_d;
    logic                    r_mem_strobe, w_mem_strobe_d;
    logic [31:0]             r_m0_data_read, w_m0_data_read_d;
    logic [31:0]             r_m1_data_read, w_m1_data_read_d;
    logic                    r_m0_ready, w_m0_ready_d;
    logic                    r_m1_ready, w_m1_ready_d;
    logic                    r_bus_error, w_bus_error_d;
    logic [CountWidth-1:0]   r_count, w_count_d;

    logic                    w_pick_m0, w_pick_m1, w_owner_strobe;

    // Round-robin choice in IDLE: on a tie the requester not served last wins.
    always_comb begin
        w_pick_m0      = i_m0_strobe && (!i_m1_strobe || r_last_grant);
        w_pick_m1      = i_m1_strobe && (!i_m0_strobe || !r_last_grant);
        w_owner_strobe = r_grant[0] ? i_m0_strobe : i_m1_strobe;
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_d            = r_state;
        w_last_grant_d       = r_last_grant;
        w_grant_d            = r_grant;
        w_mem_address_d      = r_mem_address;
        w_mem_data_write_d   = r_mem_data_write;
        w_mem_write_enable_d = r_mem_write_enable;
        w_mem_strobe_d       = r_mem_strobe;
        w_m0_data_read_d     = r_m0_data_read;
        w_m1_data_read_d     = r_m1_data_read;
        w_m0_ready_d         = r_m0_ready;
        w_m1_ready_d         = r_m1_ready;
        w_bus_error_d        = r_bus_error;
        w_count_d            = r_count;
        case (r_state)
            StIdle: begin
                if (w_pick_m0 || w_pick_m1) begin
                    w_grant_d            = {w_pick_m1, w_pick_m0};
                    w_last_grant_d       = w_pick_m1;
                    w_mem_address_d      = w_pick_m1 ? i_m1_address : i_m0_address;
                    w_mem_data_write_d   = w_pick_m1 ? i_m1_data_write : i_m0_data_write;
                    w_mem_write_enable_d = w_pick_m1 ? i_m1_write_enable : i_m0_write_enable;
                    w_mem_strobe_d       = 1'b1;
                    w_count_d            = '0;
                    w_state_d            = StBusy;
                end
            end
            StBusy: begin
                if (i_mem_ready) begin
                    w_mem_strobe_d = 1'b0;
                    if (r_grant[0]) begin
                        w_m0_data_read_d = i_mem_data_read;
                        w_m0_ready_d     = 1'b1;
                    end else begin
                        w_m1_data_read_d = i_mem_data_read;
                        w_m1_ready_d     = 1'b1;
                    end
                    w_state_d = StDone;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (r_count == LastCount) begin
                        w_mem_strobe_d = 1'b0;
                        w_bus_error_d  = 1'b1;
                        if (r_grant[0]) begin
                            w_m0_data_read_d = 32'hFFFF_FFFF;
                            w_m0_ready_d     = 1'b1;
                        end else begin
                            w_m1_data_read_d = 32'hFFFF_FFFF;
                            w_m1_ready_d     = 1'b1;
                        end
                        w_state_d = StDone;
                    end else begin
                        w_count_d = r_count + 1'b1;
                    end
                end
            end
            StDone: begin
                if (!w_owner_strobe) begin
                    w_m0_ready_d         = 1'b0;
                    w_m1_ready_d         = 1'b0;
                    w_grant_d            = 2'b00;
                    w_mem_write_enable_d = 1'b0;
                    w_state_d            = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears the bus immediately.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state            <= StIdle;
            r_last_grant       <= 1'b1;
            r_grant            <= 2'b00;
            r_mem_address      <= '0;
            r_mem_data_write   <= '0;
            r_mem_write_enable <= 1'b0;
            r_mem_strobe       <= 1'b0;
            r_m0_data_read     <= '0;
            r_m1_data_read     <= '0;
            r_m0_ready         <= 1'b0;
            r_m1_ready         <= 1'b0;
            r_bus_error        <= 1'b0;
            r_count            <= '0;
        end else begin
            r_state            <= w_state_d;
            r_last_grant       <= w_last_grant_d;
            r_grant            <= w_grant_d;
            r_mem_address      <= w_mem_address_d;
            r_mem_data_write   <= w_mem_data_write_d;
            r_mem_write_enable <= w_mem_write_enable_d;
            r_mem_strobe       <= w_mem_strobe_d;
            r_m0_data_read     <= w_m0_data_read_d;
            r_m1_data_read     <= w_m1_data_read_d;
            r_m0_ready         <= w_m0_ready_d;
            r_m1_ready         <= w_m1_ready_d;
            r_bus_error        <= w_bus_error_d;
            r_count            <= w_count_d;
        end
    end

    assign o_grant            = r_grant;
    assign o_mem_address      = r_mem_address;
    assign o_mem_data_write   = r_mem_data_write;
    assign o_mem_write_enable = r_mem_write_enable;
    assign o_mem_strobe       = r_mem_strobe;
    assign o_m0_data_read     = r_m0_data_read;
    assign o_m1_data_read     = r_m1_data_read;
    assign o_m0_ready         = r_m0_ready;
    assign o_m1_ready         = r_m1_ready;
    assign o_bus_error        = r_bus_error;

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Bench for memory_bus_arbiter: directed scenarios then random traffic, checked
// against a transaction-level round-robin / memory reference model.
module tb_memory_bus_arbiter;

    localparam int unsigned AW = 15;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          i_reset_n;
    logic [AW-1:0] i_m0_address, i_m1_address;
    logic [31:0]   i_m0_data_write, i_m1_data_write;
    logic          i_m0_write_enable, i_m1_write_enable;
    logic          i_m0_strobe, i_m1_strobe;
    logic [31:0]   o_m0_data_read, o_m1_data_read;
    logic          o_m0_ready, o_m1_ready;
    logic [AW-1:0] o_mem_address;
    logic [31:0]   o_mem_data_write;
    logic          o_mem_write_enable, o_mem_strobe;
    logic [31:0]   i_mem_data_read;
    logic          i_mem_ready;
    logic [1:0]    o_grant;
    logic          o_bus_error;

    always #5 clk = ~clk;

    memory_bus_arbiter #(
        .ADDRESS_SIZE   (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock            (clk),
        .i_reset_n          (i_reset_n),
        .i_m0_address       (i_m0_address),
        .i_m0_data_write    (i_m0_data_write),
        .i_m0_write_enable  (i_m0_write_enable),
        .i_m0_strobe        (i_m0_strobe),
        .o_m0_data_read     (o_m0_data_read),
        .o_m0_ready         (o_m0_ready),
        .i_m1_address       (i_m1_address),
        .i_m1_data_write    (i_m1_data_write),
        .i_m1_write_enable  (i_m1_write_enable),
        .i_m1_strobe        (i_m1_strobe),
        .o_m1_data_read     (o_m1_data_read),
        .o_m1_ready         (o_m1_ready),
        .o_mem_address      (o_mem_address),
        .o_mem_data_write   (o_mem_data_write),
        .o_mem_write_enable (o_mem_write_enable),
        .o_mem_strobe       (o_mem_strobe),
        .i_mem_data_read    (i_mem_data_read),
        .i_mem_ready        (i_mem_ready),
        .o_grant            (o_grant),
        .o_bus_error        (o_bus_error)
    );

    // Memory responder: ready after mem_wait wait states, never when hung.
    int          mem_wait = 0;
    bit          mem_hang = 1'b0;
    int          wait_cnt = 0;
    logic [31:0] mem_arr [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (!o_mem_strobe) wait_cnt <= 0;
        else if (wait_cnt < 1000) wait_cnt <= wait_cnt + 1;
    end
    assign i_mem_ready     = o_mem_strobe && !mem_hang && (wait_cnt == mem_wait);
    assign i_mem_data_read = mem_arr[o_mem_address];

    // Reference model state.
    int          n_checks = 0;
    int          n_fail = 0;
    bit          ref_last;  // 1 = m1 served last
    bit          ref_err;
    logic [31:0] ref_dr [2];
    logic [31:0] ref_wr [int];

    // Requester-side stimulus state.
    bit          req_on [2];
    logic [AW-1:0] req_addr [2];
    logic [31:0] req_data [2];
    bit          req_we [2];

    function automatic logic [31:0] init_pat(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
    endfunction

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
        return init_pat(32'(a));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        i_m0_address      = req_addr[0];
        i_m0_data_write   = req_data[0];
        i_m0_write_enable = req_we[0];
        i_m0_strobe       = req_on[0];
        i_m1_address      = req_addr[1];
        i_m1_data_write   = req_data[1];
        i_m1_write_enable = req_we[1];
        i_m1_strobe       = req_on[1];
    endtask

    task automatic raise(input int r);
        req_on[r]   = 1'b1;
        req_addr[r] = AW'($urandom_range(0, 15));
        req_data[r] = $urandom;
        req_we[r]   = 1'($urandom_range(0, 1));
    endtask

    // One full transaction, starting with strobes already driven while idle.
    task automatic do_txn(input int wait_states, input bit hang, input bit early_drop,
                          input bit perturb);
        int            owner;
        int            cycles;
        int            hold;
        bit            done;
        logic [AW-1:0] a;
        logic [31:0]   d;
        bit            we;
        logic [31:0]   onehot;
        if (req_on[0] && req_on[1]) owner = ref_last ? 0 : 1;
        else if (req_on[0])         owner = 0;
        else                        owner = 1;
        ref_last = (owner == 1);
        onehot   = (owner == 0) ? 32'd1 : 32'd2;
        a  = req_addr[owner];
        d  = req_data[owner];
        we = req_we[owner];
        mem_wait = wait_states;
        mem_hang = hang;
        tick();
        check("grant", 32'(o_grant), onehot);
        cycles = 0;
        done   = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            if (o_mem_strobe) begin
                cycles++;
                check("mem_addr", 32'(o_mem_address), 32'(a));
                check("mem_we", 32'(o_mem_write_enable), 32'(we));
                if (we) check("mem_wdata", o_mem_data_write, d);
                check("busy_grant", 32'(o_grant), onehot);
                check("busy_ready", 32'({o_m1_ready, o_m0_ready}), 32'd0);
                if (i == 0) begin
                    if (perturb) begin
                        req_addr[owner] = AW'($urandom_range(0, 15)) ^ AW'(16);
                        req_data[owner] = $urandom;
                        req_we[owner]   = !req_we[owner];
                    end
                    if (early_drop) req_on[owner] = 1'b0;
                    drive();
                end
                tick();
            end else begin
                done = 1'b1;
            end
        end
        check("strobe_cycles", 32'(cycles), hang ? 32'(TO) : 32'(wait_states + 1));
        ref_dr[owner] = hang ? 32'hFFFF_FFFF : ref_read(a);
        if (!hang && we) begin
            ref_wr[int'(a)] = d;
            mem_arr[a]      = d;
        end
        if (hang) ref_err = 1'b1;
        check("ready", 32'({o_m1_ready, o_m0_ready}), onehot);
        check("rdata0", o_m0_data_read, ref_dr[0]);
        check("rdata1", o_m1_data_read, ref_dr[1]);
        check("bus_error", 32'(o_bus_error), 32'(ref_err));
        if (!early_drop) begin
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("ready_hold", 32'({o_m1_ready, o_m0_ready}), onehot);
            end
            req_on[owner] = 1'b0;
            drive();
        end
        tick();
        check("released", 32'({o_grant, o_m1_ready, o_m0_ready, o_mem_strobe,
                               o_mem_write_enable}), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem_arr[i] = init_pat(32'(i));
        for (int r = 0; r < 2; r++) begin
            req_on[r] = 1'b0; req_addr[r] = '0; req_data[r] = '0; req_we[r] = 1'b0;
            ref_dr[r] = '0;
        end
        ref_last  = 1'b1;
        ref_err   = 1'b0;
        i_reset_n = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_ctrl", 32'({o_mem_strobe, o_mem_write_enable, o_m0_ready, o_m1_ready,
                               o_bus_error}), 32'd0);
        check("rst_addr", 32'(o_mem_address), 32'd0);
        check("rst_wdata", o_mem_data_write, 32'd0);
        check("rst_rdata0", o_m0_data_read, 32'd0);
        check("rst_rdata1", o_m1_data_read, 32'd0);
        i_reset_n = 1'b1;
        tick();

        // Simultaneous requests after reset: grants must alternate starting with m0.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 2; r++) if (!req_on[r]) begin
                raise(r);
                req_addr[r] = AW'(16'h100 + 16'(k * 2 + r));
                req_we[r]   = 1'b0;
            end
            drive();
            do_txn(1, 1'b0, 1'b0, 1'b0);
        end
        check("alt_grant_last", 32'(ref_last), 32'd1);
        req_on[0] = 1'b0;
        drive();
        if (o_mem_strobe || o_grant != 2'b00) tick();

        // Single read of 0x12 with two wait states.
        mem_arr[15'h12] = 32'hDEAD_BEEF;
        ref_wr[18]      = 32'hDEAD_BEEF;
        req_on[0] = 1'b1; req_addr[0] = 15'h12; req_we[0] = 1'b0; req_data[0] = 32'h0;
        drive();
        do_txn(2, 1'b0, 1'b0, 1'b0);
        check("single_rdata", o_m0_data_read, 32'hDEAD_BEEF);

        // Write latching: m1 changes its inputs while the write is in flight.
        req_on[1] = 1'b1; req_addr[1] = 15'h7FFF; req_we[1] = 1'b1;
        req_data[1] = 32'hCAFE_F00D;
        drive();
        do_txn(3, 1'b0, 1'b0, 1'b1);
        req_on[0] = 1'b1; req_addr[0] = 15'h7FFF; req_we[0] = 1'b0;
        drive();
        do_txn(0, 1'b0, 1'b0, 1'b0);
        check("write_readback", o_m0_data_read, 32'hCAFE_F00D);

        // Watchdog abort, then a normal read with the error flag still set.
        req_on[0] = 1'b1; req_addr[0] = 15'h0040; req_we[0] = 1'b0;
        drive();
        do_txn(0, 1'b1, 1'b0, 1'b0);
        check("timeout_data", o_m0_data_read, 32'hFFFF_FFFF);
        req_on[0] = 1'b1; req_addr[0] = 15'h0041;
        drive();
        do_txn(1, 1'b0, 1'b0, 1'b0);
        check("sticky_error", 32'(o_bus_error), 32'd1);

        // Early strobe drop by m1 during BUSY.
        req_on[1] = 1'b1; req_addr[1] = 15'h0005; req_we[1] = 1'b0;
        drive();
        do_txn(2, 1'b0, 1'b1, 1'b0);

        // Random traffic.
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 2; r++) if (!req_on[r] && $urandom_range(0, 1) == 1) raise(r);
            if (!req_on[0] && !req_on[1]) raise(int'($urandom_range(0, 1)));
            drive();
            do_txn(int'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                   $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end

        // Reset in the middle of a hung transaction.
        for (int r = 0; r < 2; r++) if (!req_on[r]) raise(r);
        drive();
        mem_hang = 1'b1;
        tick();
        tick();
        check("pre_rst_strobe", 32'(o_mem_strobe), 32'd1);
        i_reset_n = 1'b0;
        #1;
        check("async_rst_ctrl", 32'({o_grant, o_mem_strobe, o_m0_ready, o_m1_ready}), 32'd0);
        check("async_rst_err", 32'(o_bus_error), 32'd0);
        tick();
        i_reset_n = 1'b1;
        ref_last  = 1'b1;
        ref_err   = 1'b0;
        ref_dr[0] = '0;
        ref_dr[1] = '0;
        mem_hang  = 1'b0;
        do_txn(1, 1'b0, 1'b0, 1'b0);
        check("post_rst_owner", 32'(ref_last), 32'd0);
        do_txn(0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
